axis_sync_fifo: RTL and testbench

AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

---
 rtl/axis_sync_fifo.sv | 184 ++++++++++++++++++
 tb/tb_axis_sync_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
//
// Single-clock AXI4-Stream FIFO. Beats are carried bit-exact, in order.
// Storage is a RAM array plus an output register. count and frames include
// the beat held in the output register.
//
// Parameters
//   DATA_WIDTH : tdata width in bits. Must be a multiple of 8.
//   USER_WIDTH : tuser width in bits. tuser[0] marks start of frame.
//   DEPTH      : capacity in beats. Must be a power of 2 and at least 2.
//
// Ports
//   clk, rst                 : clock; synchronous active-high reset
//   s_tvalid/s_tready        : slave handshake
//   s_tdata/tlast/tuser/tkeep/tstrb : slave payload
//   m_tvalid/m_tready        : master handshake
//   m_tdata/tlast/tuser/tkeep/tstrb : master payload
//   count                    : stored beats, output register included
//   frames                   : stored beats that have tlast=1
//   err_proto                : sticky slave-side protocol violation flag
//
// Build option
//   AXIS_FIFO_PROTOCOL_CHECK_EN : when defined, a slave-side protocol
//   checker drives err_proto. When undefined, err_proto is tied to 0 and
//   the checker has no registers.
// -----------------------------------------------------------------------------
module axis_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tlast,
    input  logic [USER_WIDTH-1:0]         s_tuser,
    input  logic [DATA_WIDTH/8-1:0]       s_tkeep,
    input  logic [DATA_WIDTH/8-1:0]       s_tstrb,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tlast,
    output logic [USER_WIDTH-1:0]         m_tuser,
    output logic [DATA_WIDTH/8-1:0]       m_tkeep,
    output logic [DATA_WIDTH/8-1:0]       m_tstrb,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [$clog2(DEPTH+1)-1:0]    frames,
    output logic                          err_proto
);

    localparam int KW       = DATA_WIDTH / 8;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int PW       = DATA_WIDTH + 1 + USER_WIDTH + 2 * KW;
    localparam int LAST_BIT = USER_WIDTH + 2 * KW;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef logic [PW-1:0] beat_t;

    // Packed beat layout: {tdata, tlast, tuser, tkeep, tstrb}
    beat_t s_beat;
    assign s_beat = {s_tdata, s_tlast, s_tuser, s_tkeep, s_tstrb};

    beat_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   mem_cnt_reg, mem_cnt_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [CNT_W-1:0]   frames_reg, frames_next;
    logic               out_valid_reg, out_valid_next;
    beat_t              out_beat_reg;
    logic               ready_reg, ready_next;

    logic push;
    logic pop;
    logic load_out;
    logic mem_rd;
    logic bypass;
    logic mem_wr;

    always_comb begin
        push     = s_tvalid & ready_reg;
        pop      = out_valid_reg & m_tready;
        // The output register can take a new beat when it is empty or draining.
        load_out = ~out_valid_reg | pop;
        mem_rd   = load_out & (mem_cnt_reg != '0);
        // With nothing queued in RAM, a new beat goes straight to the output
        // register. This gives one-cycle latency into an empty FIFO.
        bypass   = load_out & (mem_cnt_reg == '0) & push;
        mem_wr   = push & ~bypass;

        wr_ptr_next    = mem_wr ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        rd_ptr_next    = mem_rd ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        mem_cnt_next   = mem_cnt_reg + CNT_W'(mem_wr) - CNT_W'(mem_rd);
        count_next     = count_reg + CNT_W'(push) - CNT_W'(pop);
        frames_next    = frames_reg + CNT_W'(push & s_tlast)
                                    - CNT_W'(pop & out_beat_reg[LAST_BIT]);
        out_valid_next = load_out ? (mem_rd | bypass) : out_valid_reg;
        // Ready comes from a register, so m_tready has no combinational path to it.
        ready_next     = count_next < DEPTH_C;
    end

    // RAM write port. The contents are not reset: after reset the pointers
    // and count mark every entry as empty.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= s_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_cnt_reg   <= '0;
            count_reg     <= '0;
            frames_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_beat_reg  <= '0;
            ready_reg     <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            mem_cnt_reg   <= mem_cnt_next;
            count_reg     <= count_next;
            frames_reg    <= frames_next;
            out_valid_reg <= out_valid_next;
            ready_reg     <= ready_next;
            // Registered RAM read into the output register. The payload
            // stays put while the output is stalled.
            if (mem_rd) begin
                out_beat_reg <= mem[rd_ptr_reg];
            end else if (bypass) begin
                out_beat_reg <= s_beat;
            end
        end
    end

    assign s_tready = ready_reg;
    assign m_tvalid = out_valid_reg;
    assign {m_tdata, m_tlast, m_tuser, m_tkeep, m_tstrb} = out_beat_reg;
    assign count    = count_reg;
    assign frames   = frames_reg;

`ifdef AXIS_FIFO_PROTOCOL_CHECK_EN
    logic          stall_reg;
    beat_t         held_reg;
    logic          err_reg;
    logic [KW-1:0] strb_orphan;
    logic          hold_break;
    logic          bad_keep;

    // Flag each lane where a strobe is set but its keep bit is clear.
    for (genvar gi = 0; gi < KW; gi++) begin : g_lane
        assign strb_orphan[gi] = s_tstrb[gi] & ~s_tkeep[gi];
    end

    always_comb begin
        // A stalled beat must be offered again, unchanged, on the next cycle.
        hold_break = stall_reg & (~s_tvalid | (s_beat != held_reg));
        bad_keep   = push & ((s_tkeep == '0) | (strb_orphan != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_reg <= 1'b0;
            held_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            stall_reg <= s_tvalid & ~ready_reg;
            held_reg  <= s_beat;
            err_reg   <= err_reg | hold_break | bad_keep;
        end
    end

    assign err_proto = err_reg;
`else
    assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_fifo
//
// Scoreboard bench for axis_sync_fifo with DEPTH=4 and 8-bit data.
// The driver records each beat at the moment it is accepted. A monitor runs
// once per cycle. It keeps an occupancy model (beat and frame counts), checks
// ready, valid, count, frames and err_proto against that model, and compares
// every drained beat with the front of the expected queue.
// -----------------------------------------------------------------------------
module tb_axis_sync_fifo;

    localparam int DEPTH = 4;

`ifdef AXIS_FIFO_PROTOCOL_CHECK_EN
    localparam bit EXP_ERR_ON = 1'b1;
`else
    localparam bit EXP_ERR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [0:0] user;
        logic [0:0] keep;
        logic [0:0] strb;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic [0:0] s_tuser;
    logic [0:0] s_tkeep;
    logic [0:0] s_tstrb;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] m_tdata;
    logic       m_tlast;
    logic [0:0] m_tuser;
    logic [0:0] m_tkeep;
    logic [0:0] m_tstrb;
    logic [2:0] count;
    logic [2:0] frames;
    logic       err_proto;

    axis_sync_fifo #(
        .DATA_WIDTH (8),
        .USER_WIDTH (1),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tuser   (s_tuser),
        .s_tkeep   (s_tkeep),
        .s_tstrb   (s_tstrb),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .m_tkeep   (m_tkeep),
        .m_tstrb   (m_tstrb),
        .count     (count),
        .frames    (frames),
        .err_proto (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t src_q[$];
    beat_t exp_q[$];
    bit    holding     = 1'b0;
    bit    exp_err     = 1'b0;

    // Reference model state, owned by the monitor
    int    mcnt           = 0;
    int    mfr            = 0;
    bit    last_edge_rst  = 1'b1;
    bit    acc_into_empty = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic l, input logic u,
                                 input logic k, input logic s);
        beat_t b;
        b.data = d; b.last = l; b.user = u; b.keep = k; b.strb = s;
        return b;
    endfunction

    // Monitor: sample 2 time units after the falling edge. At that point the
    // driver has set this cycle's inputs and the DUT outputs are stable.
    always @(negedge clk) begin
        beat_t b;
        bit    acc;
        bit    drn;
        bit    dlast;
        #2;
        if (last_edge_rst) begin
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_m_payload", {m_tdata, m_tlast, m_tuser, m_tkeep, m_tstrb}, 0);
            if (rst) chk("rst_s_tready", s_tready, 0);
        end else begin
            chk("s_tready", s_tready, (mcnt < DEPTH) ? 1 : 0);
        end
        chk("count", count, mcnt);
        chk("frames", frames, mfr);
        if (mcnt == 0) chk("m_tvalid_empty", m_tvalid, 0);
        if (acc_into_empty) chk("latency_m_tvalid", m_tvalid, 1);
        chk("err_proto", err_proto, exp_err);

        drn   = m_tvalid && m_tready && !rst;
        acc   = s_tvalid && s_tready && !rst;
        dlast = 1'b0;
        if (drn) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                b     = exp_q.pop_front();
                dlast = b.last;
                chk("payload", {m_tdata, m_tlast, m_tuser, m_tkeep, m_tstrb}, b);
                $display("beat out data=%02h last=%0d user=%0d keep=%0d strb=%0d",
                         m_tdata, m_tlast, m_tuser, m_tkeep, m_tstrb);
            end
        end

        if (rst) begin
            mcnt           = 0;
            mfr            = 0;
            exp_q.delete();
            last_edge_rst  = 1'b1;
            acc_into_empty = 1'b0;
        end else begin
            acc_into_empty = acc && (mcnt == 0);
            mcnt = mcnt + (acc ? 1 : 0) - (drn ? 1 : 0);
            mfr  = mfr + ((acc && s_tlast) ? 1 : 0) - ((drn && dlast) ? 1 : 0);
            last_edge_rst = 1'b0;
        end
    end

    // One driver cycle. A stalled beat stays on the bus until it is accepted.
    task automatic drive_cycle(input int pv, input int pr);
        @(negedge clk);
        if (!holding) begin
            if (src_q.size() > 0 && $urandom_range(99) < pv) begin
                s_tvalid = 1'b1;
                {s_tdata, s_tlast, s_tuser, s_tkeep, s_tstrb} = src_q[0];
            end else begin
                s_tvalid = 1'b0;
            end
        end
        m_tready = ($urandom_range(99) < pr);
        #1;
        if (s_tvalid && s_tready && !rst) begin
            exp_q.push_back(src_q.pop_front());
            holding = 1'b0;
        end else begin
            holding = s_tvalid;
        end
    endtask

    task automatic run(input int pv, input int pr, input int max_cycles, input bit until_empty);
        for (int c = 0; c < max_cycles; c++) begin
            if (until_empty && src_q.size() == 0 && exp_q.size() == 0 && !m_tvalid) break;
            drive_cycle(pv, pr);
        end
        if (until_empty)
            chk("drain_timeout", src_q.size() + exp_q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        holding  = 1'b0;
        src_q.delete();
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
        s_tdata = '0; s_tlast = 1'b0; s_tuser = '0; s_tkeep = '0; s_tstrb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single beat through an empty FIFO
        src_q.push_back(mk(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1));
        run(100, 100, 20, 1'b1);

        // Fill with the output stalled: only 4 of 5 beats are accepted
        for (int i = 1; i <= 5; i++) src_q.push_back(mk(8'(i), 1'b0, 1'b0, 1'b1, 1'b1));
        run(100, 0, 8, 1'b0);
        chk("fill_accepted", exp_q.size(), 4);
        chk("fill_full_ready", s_tready, 0);
        // Full with drain on the same cycle: nothing is accepted that cycle
        run(100, 100, 1, 1'b0);
        chk("full_drain_pending", src_q.size(), 1);
        run(100, 100, 50, 1'b1);

        // Wrap and throughput: 0x00..0x0F, then random frames
        for (int i = 0; i < 16; i++)
            src_q.push_back(mk(8'(i), (i % 4) == 3, (i % 4) == 0, 1'b1, 1'(i)));
        run(60, 60, 1000, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 24; i++)
                src_q.push_back(mk(8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'($urandom)));
            run($urandom_range(30, 100), $urandom_range(30, 100), 1000, 1'b1);
        end

        // Reset in the middle of a frame, then a clean 2-beat frame
        for (int i = 0; i < 5; i++) src_q.push_back(mk(8'h50 + 8'(i), i == 4, i == 0, 1'b1, 1'b1));
        run(100, 0, 3, 1'b0);
        chk("midframe_accepted", exp_q.size(), 3);
        do_reset(1);
        src_q.push_back(mk(8'hC0, 1'b0, 1'b1, 1'b1, 1'b1));
        src_q.push_back(mk(8'hC1, 1'b1, 1'b0, 1'b1, 1'b0));
        run(100, 100, 50, 1'b1);

        // Protocol: stalled beat changes 0x11 -> 0x22 while the FIFO is full
        for (int i = 0; i < 4; i++) src_q.push_back(mk(8'h70 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1));
        run(100, 0, 6, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b1; {s_tdata, s_tlast, s_tuser, s_tkeep, s_tstrb} = mk(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        s_tdata = 8'h22;
        @(negedge clk);
        exp_err = EXP_ERR_ON;
        repeat (3) @(negedge clk);
        do_reset(1);

        // Protocol: an accepted beat with tkeep == 0
        run(0, 0, 2, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b1; m_tready = 1'b1;
        {s_tdata, s_tlast, s_tuser, s_tkeep, s_tstrb} = mk(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        if (s_tvalid && s_tready) exp_q.push_back(mk(8'h33, 1'b1, 1'b0, 1'b0, 1'b0));
        else chk("keep0_accept", s_tready, 1);
        @(negedge clk);
        s_tvalid = 1'b0;
        exp_err  = EXP_ERR_ON;
        run(0, 100, 3, 1'b0);
        do_reset(1);
        run(0, 0, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
